// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache flush engine and the dcache controller.
//   - flush_state_e : flush engine FSM state encoding
//   - valid_bit / dirty_bit : positions of the flag bits in a tag entry
//     {valid, dirty, tag}, as a function of the tag width
//   - line_addr : line-aligned memory address {tag, index, zero offset}
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_WB     = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } flush_state_e;

  function automatic int valid_bit(input int tag_w);
    return tag_w + 1;
  endfunction

  function automatic int dirty_bit(input int tag_w);
    return tag_w;
  endfunction

  // Computed at 64 bits; callers size-cast the result to their address width.
  function automatic logic [63:0] line_addr(input logic [63:0] tag,
                                            input logic [63:0] idx,
                                            input int          index_w,
                                            input int          offset_w);
    return (tag << (index_w + offset_w)) | (idx << offset_w);
  endfunction

endpackage

// File: rtl/dcache_line_addr_gen.sv
// Combinational line-address generator shared by the dcache controller and
// the flush engine.
//   tag_i  : stored address tag of the line
//   idx_i  : cache index of the line
//   addr_o : {zero pad, tag, index, OFFSET_W'b0}
module dcache_line_addr_gen
  import dcache_pkg::*;
#(
  parameter int TAG_W    = 22,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 5,
  parameter int ADDR_W   = 32
) (
  input  logic [TAG_W-1:0]   tag_i,
  input  logic [INDEX_W-1:0] idx_i,
  output logic [ADDR_W-1:0]  addr_o
);

  assign addr_o = ADDR_W'(line_addr(64'(tag_i), 64'(idx_i), INDEX_W, OFFSET_W));

endmodule

// File: rtl/dcache_flush_engine.sv
// Write-back / invalidate engine for the direct-mapped data cache.
// On a flush request it walks every cache line, writes each valid+dirty line
// back to memory, then clears the dirty bit (and the valid bit in invalidate
// mode). It owns the SRAM and memory ports only while busy_o is high.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_req_i, inv_i   one-cycle request pulse and its mode (1 = invalidate)
//   cache_idle_i         dcache has nothing in flight; the walk waits for it
//   busy_o, done_o       engine owns the ports / one-cycle completion pulse
//   wb_count_o           lines written back by the last or current flush
//   sram_idx_o, tag_i, data_i, tag_we_o, tag_o   tag/data SRAM access
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, mem_ack_i   memory
//
// Memory handshake: mem_enable_o/mem_write_o rise when the engine enters WB
// and, together with mem_addr_o and mem_data_o, hold steady until mem_ack_i
// is sampled high on a rising edge; mem_ack_i is ignored in every other state.
module dcache_flush_engine
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int INDEX_W   = 5,
  parameter int TAG_W     = 22,
  parameter int LINE_W    = 256,
  parameter int OFFSET_W  = 5,
  parameter int ADDR_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  input  logic                inv_i,
  input  logic                cache_idle_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [INDEX_W:0]    wb_count_o,
  output logic [INDEX_W-1:0]  sram_idx_o,
  input  logic [TAG_W+1:0]    tag_i,
  input  logic [LINE_W-1:0]   data_i,
  output logic                tag_we_o,
  output logic [TAG_W+1:0]    tag_o,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic                mem_ack_i
);

  localparam int                 VALID_BIT = valid_bit(TAG_W);
  localparam int                 DIRTY_BIT = dirty_bit(TAG_W);
  localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(NUM_LINES - 1);
  localparam logic [INDEX_W-1:0] IDX_ONE   = INDEX_W'(1);
  localparam logic [INDEX_W:0]   CNT_ONE   = (INDEX_W + 1)'(1);

  flush_state_e        state_q, state_d;
  logic                pending_q, pending_d;
  logic                inv_q, inv_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                wrote_q, wrote_d;   // current line went through WB
  logic [INDEX_W:0]    wb_count_q, wb_count_d;

  logic [ADDR_W-1:0]   line_addr_w;

  logic entry_valid;
  logic entry_dirty;
  assign entry_valid = tag_i[VALID_BIT];
  assign entry_dirty = tag_i[DIRTY_BIT];

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    inv_d      = inv_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    line_d     = line_q;
    wrote_d    = wrote_q;
    wb_count_d = wb_count_q;

    // A request is accepted only when the engine is idle and nothing is
    // already pending, so the latched mode cannot change under a flush.
    if (flush_req_i && !pending_q && (state_q == ST_IDLE)) begin
      pending_d = 1'b1;
      inv_d     = inv_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q && cache_idle_i) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          wb_count_d = '0;
        end
      end
      ST_SCAN: begin
        if (entry_valid && entry_dirty) begin
          tag_d   = tag_i[TAG_W-1:0];
          line_d  = data_i;
          wrote_d = 1'b1;
          state_d = ST_WB;
        end else if (entry_valid && inv_q) begin
          tag_d   = tag_i[TAG_W-1:0];
          wrote_d = 1'b0;
          state_d = ST_UPDATE;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_WB: begin
        if (mem_ack_i) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (wrote_q) begin
          wb_count_d = wb_count_q + CNT_ONE;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        pending_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      inv_q      <= 1'b0;
      idx_q      <= '0;
      tag_q      <= '0;
      line_q     <= '0;
      wrote_q    <= 1'b0;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inv_q      <= inv_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      line_q     <= line_d;
      wrote_q    <= wrote_d;
      wb_count_q <= wb_count_d;
    end
  end

  dcache_line_addr_gen #(
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W),
    .OFFSET_W(OFFSET_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .tag_i (tag_q),
    .idx_i (idx_q),
    .addr_o(line_addr_w)
  );

  // All outputs are pure decodes of flops; port data is forced to zero
  // outside the state that owns it so reset leaves every output at 0.
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign wb_count_o   = wb_count_q;
  assign sram_idx_o   = idx_q;
  assign tag_we_o     = (state_q == ST_UPDATE);
  // Only valid lines reach UPDATE, so the new valid bit is simply ~inv.
  assign tag_o        = (state_q == ST_UPDATE) ? {~inv_q, 1'b0, tag_q} : '0;
  assign mem_enable_o = (state_q == ST_WB);
  assign mem_write_o  = (state_q == ST_WB);
  assign mem_addr_o   = (state_q == ST_WB) ? line_addr_w : '0;
  assign mem_data_o   = (state_q == ST_WB) ? line_q : '0;

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Self-checking bench for dcache_flush_engine: SRAM and memory models,
// directed scenarios plus randomized flushes against a line-walk model.
module tb_dcache_flush_engine;

  localparam int NUM_LINES = 32;
  localparam int INDEX_W   = 5;
  localparam int TAG_W     = 22;
  localparam int LINE_W    = 256;
  localparam int OFFSET_W  = 5;
  localparam int ADDR_W    = 32;
  localparam int BUDGET    = 3000;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush_req;
  logic                inv;
  logic                cache_idle;
  logic                busy_o;
  logic                done_o;
  logic [INDEX_W:0]    wb_count_o;
  logic [INDEX_W-1:0]  sram_idx_o;
  logic [TAG_W+1:0]    tag_i;
  logic [LINE_W-1:0]   data_i;
  logic                tag_we_o;
  logic [TAG_W+1:0]    tag_o;
  logic                mem_enable_o;
  logic                mem_write_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [LINE_W-1:0]   mem_data_o;
  logic                mem_ack;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  dcache_flush_engine #(
    .NUM_LINES(NUM_LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W),
    .LINE_W(LINE_W), .OFFSET_W(OFFSET_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_req_i(flush_req), .inv_i(inv),
    .cache_idle_i(cache_idle), .busy_o(busy_o), .done_o(done_o),
    .wb_count_o(wb_count_o), .sram_idx_o(sram_idx_o), .tag_i(tag_i),
    .data_i(data_i), .tag_we_o(tag_we_o), .tag_o(tag_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack)
  );

  // ---------------- SRAM model ----------------
  logic [TAG_W+1:0]  tag_ram  [NUM_LINES];
  logic [TAG_W+1:0]  load_tag [NUM_LINES];
  logic [LINE_W-1:0] data_ram [NUM_LINES];
  logic              load_req;
  int                tag_we_cnt = 0;

  assign tag_i  = tag_ram[sram_idx_o];
  assign data_i = data_ram[sram_idx_o];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NUM_LINES; i++) tag_ram[i] <= load_tag[i];
    end else if (tag_we_o) begin
      tag_ram[sram_idx_o] <= tag_o;
      tag_we_cnt <= tag_we_cnt + 1;
    end
  end

  // ---------------- memory model ----------------
  logic [ADDR_W-1:0] obs_addr_q [$];
  logic [LINE_W-1:0] obs_data_q [$];
  int                lat_cfg  = -1;   // <0 : random latency 0..4
  int                stab_err = 0;

  initial begin : mem_resp
    int                cnt;
    int                lat;
    logic              active;
    logic [ADDR_W-1:0] cap_a;
    logic [LINE_W-1:0] cap_d;
    mem_ack = 1'b0;
    active  = 1'b0;
    cnt     = 0;
    lat     = 0;
    cap_a   = '0;
    cap_d   = '0;
    forever begin
      @(negedge clk);
      if (mem_write_o !== mem_enable_o) stab_err++;
      if (!mem_enable_o) begin
        mem_ack = 1'b0;
        active  = 1'b0;
      end else if (!active) begin
        active = 1'b1;
        cnt    = 0;
        lat    = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 4));
        cap_a  = mem_addr_o;
        cap_d  = mem_data_o;
        if (lat == 0) begin
          mem_ack = 1'b1;
          obs_addr_q.push_back(cap_a);
          obs_data_q.push_back(cap_d);
        end
      end else begin
        if (mem_addr_o !== cap_a || mem_data_o !== cap_d) stab_err++;
        cnt++;
        if (cnt >= lat && !mem_ack) begin
          mem_ack = 1'b1;
          obs_addr_q.push_back(cap_a);
          obs_data_q.push_back(cap_d);
        end
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int                n_checks = 0;
  int                n_errors = 0;
  logic [ADDR_W-1:0] exp_q      [$];
  logic [LINE_W-1:0] exp_data_q [$];
  logic [TAG_W+1:0]  exp_tag    [NUM_LINES];
  int                exp_cnt;

  task automatic check(input string name, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [TAG_W+1:0] entry(input logic v, input logic d,
                                             input logic [TAG_W-1:0] t);
    return {v, d, t};
  endfunction

  // Expected result of one flush: lines written back in index order and the
  // tag array afterwards, derived from the loaded contents and the mode.
  task automatic build_model(input logic m);
    exp_q.delete();
    exp_data_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < NUM_LINES; i++) begin
      logic v, d;
      logic [TAG_W-1:0] t;
      v = load_tag[i][TAG_W+1];
      d = load_tag[i][TAG_W];
      t = load_tag[i][TAG_W-1:0];
      if (v && d) begin
        exp_q.push_back(ADDR_W'((64'(t) << (INDEX_W + OFFSET_W)) + (64'(i) << OFFSET_W)));
        exp_data_q.push_back(data_ram[i]);
        exp_cnt++;
      end
      exp_tag[i] = v ? entry(~m, 1'b0, t) : load_tag[i];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_lines();
    for (int i = 0; i < NUM_LINES; i++) begin
      load_tag[i] = '0;
      data_ram[i] = {8{$urandom()}};
    end
  endtask

  task automatic apply_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic pulse(input logic m);
    @(negedge clk);
    flush_req = 1'b1;
    inv       = m;
    @(negedge clk);
    flush_req = 1'b0;
    inv       = ~m;
  endtask

  task automatic check_quiet_outputs(input string p);
    check({p, "_busy"},   busy_o,       0);
    check({p, "_done"},   done_o,       0);
    check({p, "_idx"},    sram_idx_o,   0);
    check({p, "_tag_we"}, tag_we_o,     0);
    check({p, "_tag_o"},  tag_o,        0);
    check({p, "_men"},    mem_enable_o, 0);
    check({p, "_mwr"},    mem_write_o,  0);
    check({p, "_maddr"},  mem_addr_o,   0);
    check({p, "_mdata"},  mem_data_o,   0);
  endtask

  // Waits for done_o, counting rising edges from the current negedge, then
  // checks the whole flush against the model. inject_at >= 0 fires a request
  // with the opposite mode at that cycle while busy; it must be ignored.
  task automatic wait_and_check(input string p, input int exp_cycles,
                                input int base, input int inject_at,
                                input logic m, input int stab_base);
    int   cycles;
    int   busy_after;
    logic seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
      flush_req = 1'b0;
      if (done_o) begin
        seen = 1'b1;
      end else if (cycles == inject_at && busy_o) begin
        flush_req = 1'b1;
        inv       = ~m;
      end
    end
    flush_req = 1'b0;
    check({p, "_done_seen"}, seen, 1);
    if (exp_cycles >= 0) check({p, "_done_cycles"}, cycles, exp_cycles);
    check({p, "_busy_at_done"}, busy_o, 1);
    @(posedge clk);
    #1;
    check({p, "_done_one_cycle"}, done_o, 0);
    busy_after = 0;
    for (int k = 0; k < 3; k++) begin
      if (busy_o) busy_after++;
      @(posedge clk);
      #1;
    end
    check({p, "_idle_after"}, busy_after, 0);
    check({p, "_wb_n"}, obs_addr_q.size() - base, exp_q.size());
    for (int k = base; k < obs_addr_q.size() && exp_q.size() > 0; k++) begin
      check({p, "_wb_addr"}, obs_addr_q[k], exp_q.pop_front());
      check({p, "_wb_data"}, obs_data_q[k], exp_data_q.pop_front());
    end
    check({p, "_stable"}, stab_err - stab_base, 0);
    check({p, "_wb_count"}, wb_count_o, exp_cnt);
    for (int i = 0; i < NUM_LINES; i++) check({p, "_tag"}, tag_ram[i], exp_tag[i]);
  endtask

  task automatic run_flush(input string p, input logic m, input int exp_cycles,
                           input int inject_at);
    int base, sb;
    build_model(m);
    base = obs_addr_q.size();
    sb   = stab_err;
    pulse(m);
    wait_and_check(p, exp_cycles, base, inject_at, m, sb);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, sb, busy_cnt, we_before, guard;
    logic [TAG_W-1:0] t2;
    rst        = 1'b1;
    flush_req  = 1'b0;
    inv        = 1'b0;
    cache_idle = 1'b1;
    load_req   = 1'b0;
    clear_lines();
    apply_load();
    repeat (2) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    check("reset_wb_count", wb_count_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // all lines invalid, flush mode
    run_flush("clean", 1'b0, NUM_LINES + 1, -1);

    // line 3 dirty, 10-cycle write-back
    clear_lines();
    load_tag[3] = entry(1'b1, 1'b1, 22'h000001);
    data_ram[3] = {32{8'hA5}};
    apply_load();
    lat_cfg = 9;
    base = obs_addr_q.size();
    run_flush("line3", 1'b0, NUM_LINES + 1 + 11, -1);
    check("line3_addr", obs_addr_q[base], 32'h0000_0460);
    check("line3_word", obs_addr_q[base] >> OFFSET_W, 32'h23);
    check("line3_data", obs_data_q[base], {32{8'hA5}});

    // lines 0 and 31 dirty, line 5 clean, invalidate mode
    clear_lines();
    load_tag[0]  = entry(1'b1, 1'b1, 22'h2ABCDE);
    load_tag[5]  = entry(1'b1, 1'b0, 22'h000777);
    load_tag[31] = entry(1'b1, 1'b1, 22'h3FFFFF);
    apply_load();
    lat_cfg = 2;
    run_flush("inv3", 1'b1, NUM_LINES + 1 + 4 + 4 + 1, -1);

    // cache busy for 7 cycles; a second request must not change the mode
    clear_lines();
    load_tag[4] = entry(1'b1, 1'b0, 22'h001234);
    apply_load();
    cache_idle = 1'b0;
    build_model(1'b1);
    base = obs_addr_q.size();
    sb   = stab_err;
    pulse(1'b1);
    busy_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) pulse(1'b0);
      @(posedge clk);
      #1;
      if (busy_o) busy_cnt++;
    end
    check("wait_idle_busy", busy_cnt, 0);
    @(negedge clk);
    cache_idle = 1'b1;
    wait_and_check("wait_idle", NUM_LINES + 1 + 1, base, -1, 1'b1, sb);

    // reset in the middle of a write-back on line 2
    clear_lines();
    t2 = 22'($urandom());
    load_tag[2] = entry(1'b1, 1'b1, t2);
    apply_load();
    lat_cfg = 30;
    base = obs_addr_q.size();
    pulse(1'b0);
    guard = 0;
    while (!mem_enable_o && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("rstwb_reached_wb", mem_enable_o, 1);
    repeat (3) @(posedge clk);
    we_before = tag_we_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_quiet_outputs("rstwb");
    @(negedge clk);
    rst = 1'b0;
    check("rstwb_no_tag_write", tag_we_cnt - we_before, 0);
    check("rstwb_no_wb", obs_addr_q.size() - base, 0);
    lat_cfg = 0;
    build_model(1'b0);
    base = obs_addr_q.size();
    sb   = stab_err;
    pulse(1'b0);
    @(posedge clk);
    #1;
    check("restart_busy", busy_o, 1);
    check("restart_idx0", sram_idx_o, 0);
    // one start cycle already consumed above
    wait_and_check("restart", NUM_LINES + 2 + 1 - 1, base, -1, 1'b0, sb);

    // invalid but dirty line is left alone
    clear_lines();
    load_tag[7] = entry(1'b0, 1'b1, 22'h0ABCDE);
    apply_load();
    we_before = tag_we_cnt;
    run_flush("invdirty", 1'b0, NUM_LINES + 1, -1);
    check("invdirty_tag_we", tag_we_cnt - we_before, 0);

    // randomized contents, mode and latency, with a stray request while busy
    lat_cfg = -1;
    for (int it = 0; it < 8; it++) begin
      logic m;
      for (int i = 0; i < NUM_LINES; i++) begin
        load_tag[i] = entry(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            22'($urandom()));
        data_ram[i] = {8{$urandom()}};
      end
      apply_load();
      m = 1'($urandom_range(0, 1));
      run_flush("rand", m, -1, int'($urandom_range(1, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_flush_engine.md
Name: dcache_flush_engine

Overview:
Hardware write-back/invalidate engine for the direct-mapped data cache. On request it walks every line of the cache's tag and data SRAMs and writes each valid and dirty line back to Data_Memory. It uses the same enable/write/ack handshake the cache controller uses, then clears the dirty bit, or the valid bit as well in invalidate mode. It sits beside dcache and is muxed onto the SRAM and memory ports only while busy. It replaces backdoor end-of-simulation flushing and is parametrised in line count, tag width and line width.

Parameters:
NUM_LINES, 32, number of cache lines (power of 2)
INDEX_W, 5, log2(NUM_LINES)
TAG_W, 22, address tag bits stored per line
LINE_W, 256, line width in bits
OFFSET_W, 5, byte-offset bits per line
ADDR_W, 32, memory address width; must be at least TAG_W+INDEX_W+OFFSET_W

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
flush_req_i  in  1  one-cycle request pulse
inv_i  in  1  mode, sampled with flush_req_i; 1 = also clear valid bits
cache_idle_i  in  1  dcache has no miss or transaction in flight
busy_o  out  1  engine owns the SRAM and memory ports
done_o  out  1  one-cycle pulse when the walk is complete
wb_count_o  out  INDEX_W+1  lines written back in the last or current flush
sram_idx_o  out  INDEX_W  SRAM index
tag_i  in  TAG_W+2  tag entry {valid, dirty, tag}, combinational read of sram_idx_o
data_i  in  LINE_W  data entry, combinational read of sram_idx_o
tag_we_o  out  1  tag SRAM write enable
tag_o  out  TAG_W+2  tag write data
mem_enable_o  out  1  memory request
mem_write_o  out  1  memory write, always equal to mem_enable_o
mem_addr_o  out  ADDR_W  line address
mem_data_o  out  LINE_W  write-back data
mem_ack_i  in  1  memory completion

Behaviour:
- Reset: all outputs are 0. State is IDLE; pending, mode and index registers are cleared.
- Reset during WB abandons the memory transaction: mem_enable_o drops the next cycle and no tag write occurs.
- A flush_req_i pulse sets a pending flag and latches inv_i.
- flush_req_i while busy_o=1 or while already pending is ignored; mode is unchanged.
- IDLE: busy_o=0. When pending=1 and cache_idle_i=1, go to SCAN next cycle with idx=0 and wb_count_o=0. Pending stays set while cache_idle_i=0.
- SCAN(idx): busy_o=1, sram_idx_o=idx.
  - If valid and dirty: register tag and data, go to WB.
  - Else if valid and inv=1: go to UPDATE with no memory access.
  - Else, if idx==NUM_LINES-1 go to DONE, otherwise idx+1 and stay in SCAN.
- WB: mem_enable_o=mem_write_o=1, mem_addr_o={zero-pad, tag, idx, OFFSET_W'b0}, mem_data_o=registered data.
  - All four outputs stay stable until mem_ack_i is sampled high, then go to UPDATE; enable is low in UPDATE.
  - mem_ack_i outside WB is ignored.
- UPDATE: tag_we_o=1, sram_idx_o=idx, tag_o={valid & ~inv, 1'b0, tag}.
  - wb_count_o increments only if the line was written back.
  - Then go to DONE if idx is last, otherwise SCAN with idx+1.
- DONE: done_o=1 for exactly one cycle, busy_o still 1, pending cleared; then IDLE.
- Index wrap: idx never wraps; the last line always exits through DONE.
- wb_count_o holds its value in IDLE until the next flush starts. Maximum value is NUM_LINES.
- Timing:
  - All-clean cache, flush mode: start plus NUM_LINES SCAN cycles; done_o appears NUM_LINES+1 cycles after the start edge.
  - Each dirty line adds 1 + memory latency cycles plus 1 UPDATE cycle.
- Invalid lines are never written, even if the dirty bit is set.

Decomposition:
- Shared package dcache_pkg:
  - State encoding (IDLE, SCAN, WB, UPDATE, DONE).
  - Tag-entry field positions: VALID_BIT=TAG_W+1, DIRTY_BIT=TAG_W.
  - Address-composition function {tag, index, offset}.
- One natural sub-module, dcache_line_addr_gen: combinational assembly of mem_addr_o from tag, idx and parameters, shared with the dcache controller.
- The FSM stays in the top module.

Test Plan:
- All 32 lines invalid, flush pulse, inv=0 -> no mem_enable_o, done_o at start+33 cycles, wb_count_o=0.
- Line 3 = {1,1,tag 0x000001}, data 0xA5 repeated; memory ack after 10 cycles -> mem_addr_o=0x00000460, data stable for all 10 cycles, line 3 tag becomes {1,0,0x000001}, wb_count_o=1, memory word 0x23 = 0xA5 repeated.
- Lines 0 and 31 dirty, line 5 valid clean, inv=1 -> two write-backs, indices in order 0 then 31, valid cleared on lines 0, 5 and 31, wb_count_o=2.
- Flush pulse while cache_idle_i=0 for 7 cycles -> busy_o stays 0 until cache_idle_i rises; a second pulse meanwhile does not change the latched mode.
- rst_i asserted mid-WB on line 2 -> next cycle all outputs 0, no tag write, state IDLE; a new flush afterwards restarts at idx 0 and writes back line 2.
- Line 7 {0,1,tag} (invalid but dirty) -> no memory request, no tag write, wb_count_o=0.
